// File: rtl/gf180mcu_rstseq_pkg.sv
// Shared types for the reset-release sequencer: state encodings and counter sizing.
`timescale 1ns/1ps
package gf180mcu_rstseq_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RESET = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_SOFT  = 3'd3,
    ST_ACKW  = 3'd4
  } state_e;

  // Counter must hold the larger of the two phase lengths without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_rst_sync.sv
// Release synchroniser: a shift chain fed with 1 and cleared asynchronously by rst,
// so assertion is immediate and release reaches sync_o after STAGES clock edges.
`timescale 1ns/1ps
module gf180mcu_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_rst_release_seq.sv
// Reset-release sequencer for negedge-clocked flop banks: async assert, synchronised and
// stretched release on CLK rise. Soft-reset handshake enabled by GF180MCU_RSTSEQ_SOFTRST_EN.
//
// state | meaning
// RESET | waiting for synchronised release, RN low
// HOLD  | RN held low for HOLD_CYCLES edges
// RUN   | RN high, normal operation
// SOFT  | soft-reset pulse, RN low for PULSE_CYCLES edges
// ACKW  | soft reset done, SACK high until SREQ drops
`timescale 1ns/1ps
module gf180mcu_rst_release_seq
  import gf180mcu_rstseq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 8,
  parameter int PULSE_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SREQ,
  output logic            SACK,
  output logic            RN,
  output logic            READY,
  output logic [ST_W-1:0] STATE
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
`endif

  logic            sync_rel;
  logic [ST_W-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rn_q, rn_d;
  logic            ready_q, ready_d;

  gf180mcu_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .rst    (RST),
    .sync_o (sync_rel)
  );

`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
  logic soft_q, soft_d;
  logic sack_q, sack_d;
`else
  logic unused_sreq;
  assign unused_sreq = SREQ;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
    soft_d  = soft_q;
`endif
    case (state_q)
      ST_RESET: begin
        cnt_d = '0;
        if (sync_rel) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
          // HOLD is shared by power-on release and soft reset; the flag picks the exit.
          state_d = soft_q ? ST_ACKW : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        cnt_d = '0;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
        if (SREQ) begin
          state_d = ST_SOFT;
          soft_d  = 1'b1;
        end
`endif
      end
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
      ST_SOFT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_ACKW: begin
        cnt_d  = '0;
        soft_d = 1'b0;
        if (!SREQ) state_d = ST_RUN;
      end
`endif
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
        soft_d  = 1'b0;
`endif
      end
    endcase
  end

  // Outputs are registered from the next state so they change only on CLK rise.
  always_comb begin
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
    rn_d   = (state_d == ST_RUN) || (state_d == ST_ACKW);
    sack_d = (state_d == ST_ACKW);
`else
    rn_d   = (state_d == ST_RUN);
`endif
    ready_d = rn_q & rn_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      rn_q    <= 1'b0;
      ready_q <= 1'b0;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
      soft_q  <= 1'b0;
      sack_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rn_q    <= rn_d;
      ready_q <= ready_d;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
      soft_q  <= soft_d;
      sack_q  <= sack_d;
`endif
    end
  end

  assign RN    = rn_q;
  assign READY = ready_q;
  assign STATE = state_q;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
  assign SACK  = sack_q;
`else
  assign SACK  = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_rst_release_seq.sv
// Self-checking bench for gf180mcu_rst_release_seq, with an edge-timeline reference model.
`timescale 1ns/1ps
module tb_gf180mcu_rst_release_seq;

  localparam int S = 2;
  localparam int H = 8;
  localparam int P = 4;
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst, sreq;
  logic       sack, rn, ready;
  logic [2:0] state;
  logic       rst2, sreq2;
  logic       sack2, rn2, ready2;
  logic [2:0] state2;

  int tests = 0;
  int fails = 0;

  gf180mcu_rst_release_seq dut (
    .CLK(clk), .RST(rst), .SREQ(sreq), .SACK(sack), .RN(rn), .READY(ready), .STATE(state)
  );

  gf180mcu_rst_release_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .PULSE_CYCLES(4)) dut2 (
    .CLK(clk), .RST(rst2), .SREQ(sreq2), .SACK(sack2), .RN(rn2), .READY(ready2), .STATE(state2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: n counts edges since release; m_rise is the edge at which RN must rise.
  int         m_n, m_rise, m_soft;
  bit         m_rn, m_ready, m_sack;
  logic [2:0] m_state;

  task automatic mdl_reset();
    m_n = 0; m_rise = S + 1 + H; m_soft = -1;
    m_rn = 0; m_ready = 0; m_sack = 0; m_state = 3'd0;
  endtask

  task automatic mdl_edge(input bit req);
    bit prev_rn;
    prev_rn = m_rn;
    m_n++;
    if (m_n < m_rise) begin
      m_rn = 0; m_sack = 0;
      if (m_soft < 0) m_state = (m_n <= S) ? 3'd0 : 3'd1;
      else            m_state = (m_n < m_soft + P) ? 3'd3 : 3'd1;
    end else if (m_n == m_rise) begin
      m_rn = 1;
      m_sack = (m_soft >= 0);
      m_state = (m_soft >= 0) ? 3'd4 : 3'd2;
    end else if (m_state == 3'd2 && req && SOFT_EN) begin
      m_soft = m_n; m_rise = m_n + P + H;
      m_rn = 0; m_sack = 0; m_state = 3'd3;
    end else if (m_state == 3'd4 && !req) begin
      m_state = 3'd2; m_sack = 0; m_soft = -1;
    end
    m_ready = prev_rn && m_rn;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) mdl_reset();
    else     mdl_edge(sreq);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sreq = 0; mdl_reset();
    #1;
    tests++;
    if ({rn, ready, sack, state} !== 6'b000_000) begin
      fails++; $display("FAIL reset_async: got rn=%b rdy=%b sack=%b st=%0d exp all 0", rn, ready, sack, state);
    end
    for (int i = 0; i < 3; i++) tick();
    #4 rst = 0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL reset_seq e%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          i, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
      if (i == 10 || i == 11 || i == 12) begin
        tests++;
        if ({rn, ready, state} !== ((i == 10) ? 5'b0_0_001 : (i == 11) ? 5'b1_0_010 : 5'b1_1_010)) begin
          fails++; $display("FAIL reset_latency e%0d: got rn=%b rdy=%b st=%0d", i, rn, ready, state);
        end
      end
    end
  endtask

  task automatic test_async_rst();
    tick(); tick();
    #3 rst = 1; mdl_reset();
    #1;
    tests++;
    if ({rn, ready, sack, state} !== 6'b000_000) begin
      fails++; $display("FAIL async_rst: got rn=%b rdy=%b sack=%b st=%0d exp all 0", rn, ready, sack, state);
    end
    #2 rst = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL async_rst_seq e%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          i, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
      if (i == 10 || i == 11) begin
        tests++;
        if (rn !== (i == 11)) begin
          fails++; $display("FAIL async_rst_latency e%0d: got rn=%b exp %b", i, rn, (i == 11));
        end
      end
    end
  endtask

`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
  task automatic test_soft();
    sreq = 1;
    tick();
    tests++;
    if ({rn, ready, state} !== 5'b0_0_011) begin
      fails++; $display("FAIL soft_enter: got rn=%b rdy=%b st=%0d exp rn=0 rdy=0 st=3", rn, ready, state);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL soft_seq k+%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          j, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
    end
    tests++;
    if ({rn, sack, state} !== 5'b1_1_100) begin
      fails++; $display("FAIL soft_ack k+12: got rn=%b sack=%b st=%0d exp rn=1 sack=1 st=4", rn, sack, state);
    end
    tick();
    tests++;
    if ({ready, sack} !== 2'b11) begin
      fails++; $display("FAIL soft_ack_hold: got rdy=%b sack=%b exp 1 1", ready, sack);
    end
    sreq = 0;
    tick();
    tests++;
    if ({rn, ready, sack, state} !== 6'b1_1_0_010) begin
      fails++; $display("FAIL soft_release: got rn=%b rdy=%b sack=%b st=%0d exp 1 1 0 2", rn, ready, sack, state);
    end
  endtask

  task automatic test_sreq_poweron();
    rst = 1; sreq = 1; mdl_reset();
    tick();
    #4 rst = 0;
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (i == 14) sreq = 0;
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL poweron_seq e%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          i, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
      if (i == 11 || i == 12) begin
        tests++;
        if (state !== ((i == 11) ? 3'd2 : 3'd3)) begin
          fails++; $display("FAIL poweron_accept e%0d: got st=%0d exp %0d", i, state, (i == 11) ? 2 : 3);
        end
      end
    end
    tests++;
    if ({sack, state} !== 4'b0_010) begin
      fails++; $display("FAIL poweron_end: got sack=%b st=%0d exp 0 2", sack, state);
    end
  endtask

  task automatic test_rst_during_soft();
    sreq = 1;
    tick(); tick(); tick();
    #3 rst = 1; mdl_reset();
    #1;
    tests++;
    if ({rn, sack, state} !== 5'b0_0_000) begin
      fails++; $display("FAIL rst_in_soft: got rn=%b sack=%b st=%0d exp 0 0 0", rn, sack, state);
    end
    sreq = 0;
    #2 rst = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL rst_in_soft_seq e%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          i, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
    end
  endtask
`else
  task automatic test_no_softrst();
    for (int i = 0; i < 20; i++) begin
      sreq = ~sreq;
      tick();
      tests++;
      if ({rn, sack, state} !== 5'b1_0_010) begin
        fails++; $display("FAIL no_softrst i%0d: got rn=%b sack=%b st=%0d exp 1 0 2", i, rn, sack, state);
      end
    end
    sreq = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) sreq = ~sreq;
      if ($urandom_range(199) == 0) begin
        #4 rst = 1; mdl_reset();
        #1;
        tests++;
        if ({rn, ready, sack, state} !== 6'b000_000) begin
          fails++; $display("FAIL random_rst i%0d: got rn=%b rdy=%b sack=%b st=%0d exp all 0", i, rn, ready, sack, state);
        end
        #1 rst = 0;
      end
      tick();
      tests++;
      if ({rn, ready, sack, state} !== {m_rn, m_ready, m_sack, m_state}) begin
        fails++; $display("FAIL random i%0d: got rn=%b rdy=%b sack=%b st=%0d exp rn=%b rdy=%b sack=%b st=%0d",
                          i, rn, ready, sack, state, m_rn, m_ready, m_sack, m_state);
      end
    end
    sreq = 0;
  endtask

  task automatic test_short_params();
    tests++;
    if ({rn2, ready2, sack2, state2} !== 6'b000_000) begin
      fails++; $display("FAIL short_reset: got rn=%b rdy=%b sack=%b st=%0d exp all 0", rn2, ready2, sack2, state2);
    end
    #4 rst2 = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      tests++;
      if ({rn2, ready2} !== {(i >= 5), (i >= 6)}) begin
        fails++; $display("FAIL short_latency e%0d: got rn=%b rdy=%b exp rn=%b rdy=%b", i, rn2, ready2, (i >= 5), (i >= 6));
      end
    end
  endtask

  initial begin
    rst = 1; sreq = 0; rst2 = 1; sreq2 = 0;
    test_reset();
    test_async_rst();
`ifdef GF180MCU_RSTSEQ_SOFTRST_EN
    test_soft();
    test_sreq_poweron();
    test_rst_during_soft();
`else
    test_no_softrst();
`endif
    test_random();
    test_short_params();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
